// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-port req/ack round-robin arbiter in front of one RAM.
// Define RAM_ARB_FIXED_PRIO_EN to make port 0 win every tie.
module ram_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          starve0,
  output logic          starve1,
  output logic [AW-1:0] ram_addr,
  output logic          ram_write,
  output logic [DW-1:0] ram_value,
  input  logic [DW-1:0] ram_result
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_ACCESS
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last;
  logic          r_win;
  logic          r_we;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_write;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_value;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic [CW-1:0] r_cnt0;
  logic [CW-1:0] r_cnt1;

  logic          w_take;
  logic          w_sel;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_own0;
  logic          w_own1;

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_sel  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_take = 1'b1;
          w_next = S_GRANT;
          if (req0 && req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            w_sel = 1'b0;
`else
            w_sel = ~r_last;
`endif
          end else begin
            w_sel = req1;
          end
        end
      end
      S_GRANT:  w_next = S_ACCESS;
      S_ACCESS: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_we    = w_sel ? we1 : we0;
  assign w_addr  = w_sel ? addr1 : addr0;
  assign w_wdata = w_sel ? wdata1 : wdata0;

  // A port "owns" the RAM from the cycle it wins until its ack cycle.
  assign w_own0 = (w_take && !w_sel) ||
                  (r_state != S_IDLE && !r_win);
  assign w_own1 = (w_take && w_sel) ||
                  (r_state != S_IDLE && r_win);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_win    <= 1'b0;
      r_we     <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_value  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_cnt0   <= '0;
      r_cnt1   <= '0;
    end else begin
      r_state <= w_next;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_write <= 1'b0;
      if (w_take) begin
        r_win   <= w_sel;
        r_last  <= w_sel;
        r_we    <= w_we;
        r_addr  <= w_addr;
        r_value <= w_wdata;
        r_write <= w_we;
      end
      if (r_state == S_GRANT) begin
        r_ack0 <= ~r_win;
        r_ack1 <= r_win;
        if (!r_we && !r_win) r_rdata0 <= ram_result;
        if (!r_we && r_win)  r_rdata1 <= ram_result;
      end
      if (!req0 || w_own0)   r_cnt0 <= '0;
      else if (r_cnt0 != MAXC) r_cnt0 <= r_cnt0 + 1'b1;
      if (!req1 || w_own1)   r_cnt1 <= '0;
      else if (r_cnt1 != MAXC) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign ram_addr  = r_addr;
  assign ram_write = r_write;
  assign ram_value = r_value;
  assign starve0   = (r_cnt0 == MAXC);
  assign starve1   = (r_cnt1 == MAXC);

endmodule
